// File: rtl/mem_view_if.sv
// Debug memory-view bus: button/switch/breakpoint inputs toward the
// controller, and read address plus display status back out.
interface mem_view_if;
    logic       mode_btn;
    logic [5:0] addr_in;
    logic       at_breakpoint;
    logic [6:0] read_addr;
    logic [5:0] led;
    logic       high_low;
    logic       mode;
    logic       in_brk;
    logic       step;

    modport master (
        output mode_btn, addr_in, at_breakpoint,
        input  read_addr, led, high_low, mode, in_brk, step
    );

    modport slave (
        input  mode_btn, addr_in, at_breakpoint,
        output read_addr, led, high_low, mode, in_brk, step
    );
endinterface

// File: rtl/mem_view_ctrl.sv
// Debug memory-view controller: sequences the CPU debug read address for the
// seven-segment display and LEDs in auto-scan, manual select and breakpoint
// watch-window behaviours.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | auto-advance through all words/halves, one step per tick
// SELECT   | follow the switch word index, alternate halves per tick
// BRK_VIEW | CPU halted: cycle the watch window, scan address saved
module mem_view_ctrl #(
    parameter int TICK_DIV   = 25_000_000,
    parameter int SCAN_LAST  = 63,
    parameter int WATCH_LAST = 7
) (
    input  logic      clk,
    input  logic      rst,
    mem_view_if.slave bus
);
    localparam int         CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [6:0] SCAN_END  = {6'(SCAN_LAST), 1'b1};
    localparam logic [6:0] WATCH_END = {6'(WATCH_LAST), 1'b1};

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        SELECT   = 2'd1,
        BRK_VIEW = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] presc_q;
    logic          mode_btn_q;
    logic          brk_q;
    logic [6:0]    read_addr_q;
    logic [6:0]    save_addr_q;
    logic          mode_q;
    logic          in_brk_q;
    logic          step_q;

    logic          mode_edge;
    logic          brk_rise;
    logic          brk_fall;
    logic          tick;
    logic          mode_d;
    logic          addr_diff;
    logic [6:0]    sel_addr;

    assign mode_edge = bus.mode_btn & ~mode_btn_q;
    assign brk_rise  = bus.at_breakpoint & ~brk_q;
    assign brk_fall  = ~bus.at_breakpoint & brk_q;
    assign tick      = (presc_q == CW'(TICK_DIV - 1));
    // Mode after this cycle's button edge; the breakpoint exit target uses it.
    assign mode_d    = mode_edge ? ~mode_q : mode_q;
    assign sel_addr  = {bus.addr_in, 1'b0};
    assign addr_diff = (bus.addr_in != read_addr_q[6:1]);

    // Edge detectors, prescaler and mode FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SCAN;
            presc_q     <= '0;
            mode_btn_q  <= 1'b0;
            brk_q       <= 1'b0;
            read_addr_q <= '0;
            save_addr_q <= '0;
            mode_q      <= 1'b0;
            in_brk_q    <= 1'b0;
            step_q      <= 1'b0;
        end else begin
            mode_btn_q <= bus.mode_btn;
            brk_q      <= bus.at_breakpoint;
            step_q     <= 1'b0;
            presc_q    <= tick ? '0 : presc_q + CW'(1);

            if (brk_rise) begin
                mode_q      <= mode_d;
                save_addr_q <= read_addr_q;
                read_addr_q <= '0;
                in_brk_q    <= 1'b1;
                state_q     <= BRK_VIEW;
                presc_q     <= '0;
                step_q      <= 1'b1;
            end else if (state_q == BRK_VIEW && brk_fall) begin
                mode_q      <= mode_d;
                in_brk_q    <= 1'b0;
                state_q     <= mode_d ? SELECT : SCAN;
                read_addr_q <= mode_d ? sel_addr : save_addr_q;
                presc_q     <= '0;
                step_q      <= 1'b1;
            end else if (mode_edge) begin
                // Inside the watch window only the mode flag flips.
                mode_q  <= mode_d;
                presc_q <= '0;
                if (state_q == SCAN) begin
                    state_q     <= SELECT;
                    read_addr_q <= sel_addr;
                    step_q      <= 1'b1;
                end else if (state_q == SELECT) begin
                    state_q     <= SCAN;
                    read_addr_q <= '0;
                    step_q      <= 1'b1;
                end
            end else if (state_q == SELECT && addr_diff) begin
                read_addr_q <= sel_addr;
                presc_q     <= '0;
                step_q      <= 1'b1;
            end else if (tick) begin
                step_q <= 1'b1;
                case (state_q)
                    SCAN:    read_addr_q <= (read_addr_q == SCAN_END) ? '0 : read_addr_q + 7'd1;
                    SELECT:  read_addr_q <= {read_addr_q[6:1], ~read_addr_q[0]};
                    default: read_addr_q <= (read_addr_q == WATCH_END) ? '0 : read_addr_q + 7'd1;
                endcase
            end
        end
    end

    assign bus.read_addr = read_addr_q;
    assign bus.led       = read_addr_q[6:1];
    assign bus.high_low  = ~read_addr_q[0];
    assign bus.mode      = mode_q;
    assign bus.in_brk    = in_brk_q;
    assign bus.step      = step_q;
endmodule

// File: tb/tb_mem_view_ctrl.sv
module tb_mem_view_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mem_view_if u_bus();

    mem_view_ctrl #(
        .TICK_DIV  (4),
        .SCAN_LAST (63),
        .WATCH_LAST(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_bus)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        checks++; if (u_bus.read_addr !== 7'd0) begin errors++; $display("FAIL rst_read_addr actual=%0d required=0", u_bus.read_addr); end
        checks++; if (u_bus.led !== 6'd0) begin errors++; $display("FAIL rst_led actual=%0d required=0", u_bus.led); end
        checks++; if (u_bus.high_low !== 1'b1) begin errors++; $display("FAIL rst_high_low actual=%b required=1", u_bus.high_low); end
        checks++; if (u_bus.mode !== 1'b0) begin errors++; $display("FAIL rst_mode actual=%b required=0", u_bus.mode); end
        checks++; if (u_bus.in_brk !== 1'b0) begin errors++; $display("FAIL rst_in_brk actual=%b required=0", u_bus.in_brk); end
        checks++; if (u_bus.step !== 1'b0) begin errors++; $display("FAIL rst_step actual=%b required=0", u_bus.step); end
    endtask

    // Starts at the negedge of reset release; ends at read_addr=1, prescaler 0.
    task automatic test_scan_wrap;
        logic [6:0] e;
        logic [6:0] p;
        for (int k = 1; k <= 129; k++) begin
            p = 7'((k - 1) % 128);
            e = 7'(k % 128);
            repeat (3) @(negedge clk);
            checks++; if (u_bus.read_addr !== p || u_bus.step !== 1'b0) begin errors++; $display("FAIL scan_hold k=%0d actual=%0d/%b required=%0d/0", k, u_bus.read_addr, u_bus.step, p); end
            @(negedge clk);
            checks++; if (u_bus.read_addr !== e) begin errors++; $display("FAIL scan_addr k=%0d actual=%0d required=%0d", k, u_bus.read_addr, e); end
            checks++; if (u_bus.step !== 1'b1) begin errors++; $display("FAIL scan_step k=%0d actual=%b required=1", k, u_bus.step); end
            checks++; if (u_bus.high_low !== ~e[0] || u_bus.led !== e[6:1]) begin errors++; $display("FAIL scan_status k=%0d actual=%b/%0d required=%b/%0d", k, u_bus.high_low, u_bus.led, ~e[0], e[6:1]); end
        end
    endtask

    task automatic test_select;
        u_bus.addr_in  = 6'd5;
        u_bus.mode_btn = 1'b1;
        @(negedge clk);
        u_bus.mode_btn = 1'b0;
        checks++; if (u_bus.mode !== 1'b1) begin errors++; $display("FAIL sel_mode actual=%b required=1", u_bus.mode); end
        checks++; if (u_bus.read_addr !== 7'd10 || u_bus.led !== 6'd5) begin errors++; $display("FAIL sel_entry actual=%0d/%0d required=10/5", u_bus.read_addr, u_bus.led); end
        checks++; if (u_bus.step !== 1'b1) begin errors++; $display("FAIL sel_entry_step actual=%b required=1", u_bus.step); end
        repeat (3) @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd10 || u_bus.step !== 1'b0) begin errors++; $display("FAIL sel_hold actual=%0d/%b required=10/0", u_bus.read_addr, u_bus.step); end
        @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd11 || u_bus.step !== 1'b1) begin errors++; $display("FAIL sel_toggle1 actual=%0d/%b required=11/1", u_bus.read_addr, u_bus.step); end
        repeat (4) @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd10) begin errors++; $display("FAIL sel_toggle2 actual=%0d required=10", u_bus.read_addr); end
        repeat (4) @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd11) begin errors++; $display("FAIL sel_toggle3 actual=%0d required=11", u_bus.read_addr); end
        u_bus.addr_in = 6'd9;
        @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd18 || u_bus.step !== 1'b1) begin errors++; $display("FAIL sel_change actual=%0d/%b required=18/1", u_bus.read_addr, u_bus.step); end
        repeat (3) @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd18 || u_bus.step !== 1'b0) begin errors++; $display("FAIL sel_change_hold actual=%0d/%b required=18/0", u_bus.read_addr, u_bus.step); end
        @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd19 || u_bus.step !== 1'b1) begin errors++; $display("FAIL sel_change_tick actual=%0d/%b required=19/1", u_bus.read_addr, u_bus.step); end
    endtask

    task automatic test_watch;
        logic [6:0] e;
        u_bus.mode_btn = 1'b1;
        @(negedge clk);
        u_bus.mode_btn = 1'b0;
        checks++; if (u_bus.mode !== 1'b0 || u_bus.read_addr !== 7'd0 || u_bus.step !== 1'b1) begin errors++; $display("FAIL scan_reentry actual=%b/%0d/%b required=0/0/1", u_bus.mode, u_bus.read_addr, u_bus.step); end
        repeat (148) @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd37) begin errors++; $display("FAIL watch_pre actual=%0d required=37", u_bus.read_addr); end
        u_bus.at_breakpoint = 1'b1;
        @(negedge clk);
        checks++; if (u_bus.in_brk !== 1'b1 || u_bus.read_addr !== 7'd0 || u_bus.step !== 1'b1) begin errors++; $display("FAIL watch_entry actual=%b/%0d/%b required=1/0/1", u_bus.in_brk, u_bus.read_addr, u_bus.step); end
        for (int k = 1; k <= 9; k++) begin
            e = 7'(k % 8);
            repeat (4) @(negedge clk);
            checks++; if (u_bus.read_addr !== e) begin errors++; $display("FAIL watch_cycle k=%0d actual=%0d required=%0d", k, u_bus.read_addr, e); end
        end
        u_bus.at_breakpoint = 1'b0;
        @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd37 || u_bus.step !== 1'b1) begin errors++; $display("FAIL watch_restore actual=%0d/%b required=37/1", u_bus.read_addr, u_bus.step); end
        checks++; if (u_bus.in_brk !== 1'b0 || u_bus.mode !== 1'b0) begin errors++; $display("FAIL watch_exit actual=%b/%b required=0/0", u_bus.in_brk, u_bus.mode); end
    endtask

    task automatic test_coincident;
        u_bus.addr_in       = 6'd12;
        u_bus.mode_btn      = 1'b1;
        u_bus.at_breakpoint = 1'b1;
        @(negedge clk);
        u_bus.mode_btn = 1'b0;
        checks++; if (u_bus.in_brk !== 1'b1 || u_bus.mode !== 1'b1 || u_bus.read_addr !== 7'd0) begin errors++; $display("FAIL coin_entry actual=%b/%b/%0d required=1/1/0", u_bus.in_brk, u_bus.mode, u_bus.read_addr); end
        repeat (6) @(negedge clk);
        u_bus.at_breakpoint = 1'b0;
        @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd24 || u_bus.in_brk !== 1'b0 || u_bus.mode !== 1'b1) begin errors++; $display("FAIL coin_exit actual=%0d/%b/%b required=24/0/1", u_bus.read_addr, u_bus.in_brk, u_bus.mode); end
        u_bus.addr_in = 6'd20;
        @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd40) begin errors++; $display("FAIL coin_select_follow actual=%0d required=40", u_bus.read_addr); end
        repeat (3) @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd40) begin errors++; $display("FAIL coin_select_hold actual=%0d required=40", u_bus.read_addr); end
        @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd41) begin errors++; $display("FAIL coin_select_tick actual=%0d required=41", u_bus.read_addr); end
    endtask

    task automatic test_brk_mode;
        u_bus.mode_btn = 1'b1;
        @(negedge clk);
        u_bus.mode_btn = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd3 || u_bus.mode !== 1'b0) begin errors++; $display("FAIL bm_pre actual=%0d/%b required=3/0", u_bus.read_addr, u_bus.mode); end
        u_bus.at_breakpoint = 1'b1;
        @(negedge clk);
        checks++; if (u_bus.in_brk !== 1'b1 || u_bus.read_addr !== 7'd0) begin errors++; $display("FAIL bm_entry actual=%b/%0d required=1/0", u_bus.in_brk, u_bus.read_addr); end
        repeat (2) @(negedge clk);
        u_bus.mode_btn = 1'b1;
        @(negedge clk);
        u_bus.mode_btn = 1'b0;
        checks++; if (u_bus.mode !== 1'b1 || u_bus.read_addr !== 7'd0 || u_bus.in_brk !== 1'b1) begin errors++; $display("FAIL bm_press1 actual=%b/%0d/%b required=1/0/1", u_bus.mode, u_bus.read_addr, u_bus.in_brk); end
        repeat (3) @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd0) begin errors++; $display("FAIL bm_presc_clear actual=%0d required=0", u_bus.read_addr); end
        @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd1) begin errors++; $display("FAIL bm_step1 actual=%0d required=1", u_bus.read_addr); end
        u_bus.mode_btn = 1'b1;
        @(negedge clk);
        u_bus.mode_btn = 1'b0;
        checks++; if (u_bus.mode !== 1'b0 || u_bus.read_addr !== 7'd1) begin errors++; $display("FAIL bm_press2 actual=%b/%0d required=0/1", u_bus.mode, u_bus.read_addr); end
        repeat (4) @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd2) begin errors++; $display("FAIL bm_step2 actual=%0d required=2", u_bus.read_addr); end
        u_bus.at_breakpoint = 1'b0;
        @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd3 || u_bus.in_brk !== 1'b0 || u_bus.mode !== 1'b0) begin errors++; $display("FAIL bm_restore actual=%0d/%b/%b required=3/0/0", u_bus.read_addr, u_bus.in_brk, u_bus.mode); end
    endtask

    task automatic test_reset_mid;
        u_bus.mode_btn      = 1'b1;
        u_bus.at_breakpoint = 1'b1;
        @(negedge clk);
        u_bus.mode_btn = 1'b0;
        checks++; if (u_bus.in_brk !== 1'b1 || u_bus.mode !== 1'b1) begin errors++; $display("FAIL rm_entry actual=%b/%b required=1/1", u_bus.in_brk, u_bus.mode); end
        repeat (20) @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd5) begin errors++; $display("FAIL rm_pre actual=%0d required=5", u_bus.read_addr); end
        #2 rst = 1'b0;
        #1;
        checks++; if (u_bus.read_addr !== 7'd0 || u_bus.led !== 6'd0 || u_bus.high_low !== 1'b1) begin errors++; $display("FAIL rm_async_addr actual=%0d/%0d/%b required=0/0/1", u_bus.read_addr, u_bus.led, u_bus.high_low); end
        checks++; if (u_bus.mode !== 1'b0 || u_bus.in_brk !== 1'b0 || u_bus.step !== 1'b0) begin errors++; $display("FAIL rm_async_flags actual=%b/%b/%b required=0/0/0", u_bus.mode, u_bus.in_brk, u_bus.step); end
        u_bus.at_breakpoint = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd0 || u_bus.step !== 1'b0) begin errors++; $display("FAIL rm_restart_hold actual=%0d/%b required=0/0", u_bus.read_addr, u_bus.step); end
        @(negedge clk);
        checks++; if (u_bus.read_addr !== 7'd1 || u_bus.step !== 1'b1 || u_bus.mode !== 1'b0) begin errors++; $display("FAIL rm_restart_step actual=%0d/%b/%b required=1/1/0", u_bus.read_addr, u_bus.step, u_bus.mode); end
    endtask

    initial begin
        u_bus.mode_btn      = 1'b0;
        u_bus.addr_in       = 6'd0;
        u_bus.at_breakpoint = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_scan_wrap();
        test_select();
        test_watch();
        test_coincident();
        test_brk_mode();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_view_ctrl.md
# mem_view_ctrl

- Sequences the debug memory-read port that feeds the seven-segment display and LEDs.
- Replaces the separate scan generator, single-address generator and mode toggle with one clocked controller.
- Supports three behaviours: auto-scan of all words, manual word select, and a breakpoint watch window.
- Drives the CPU's debug read address (word + half select) and the display status outputs.

## Interface

Parameters:
- TICK_DIV, 25_000_000: clk cycles per display step; min 2.
- SCAN_LAST, 63: last word index in the auto-scan range (0..63).
- WATCH_LAST, 7: last word index in the breakpoint watch window (0..SCAN_LAST).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-low.
- mode_btn  in  1  debounced mode button, level; a rising edge toggles scan/select mode.
- addr_in  in  6  word index from switches, used in select mode.
- at_breakpoint  in  1  CPU halted-at-breakpoint level.
- read_addr  out  7  [6:1] is the word index, [0] is the half (0 = bits 31:16, 1 = bits 15:0).
- led  out  6  equals read_addr[6:1].
- high_low  out  1  equals ~read_addr[0].
- mode  out  1  0 = scan, 1 = select; shows the selected mode even while in the watch window.
- in_brk  out  1  high while in BRK_VIEW.
- step  out  1  one-cycle pulse in every cycle read_addr is loaded.

## Operation

- Prescaler:
  - Counts 0..TICK_DIV-1; tick = (count == TICK_DIV-1); wraps to 0.
  - Cleared to 0 on every mode change, breakpoint entry/exit, and select-mode address change.
- Edge detection:
  - mode_btn and at_breakpoint are each registered once (m_d, b_d).
  - mode_edge = mode_btn & ~m_d; brk_rise = at_breakpoint & ~b_d; brk_fall = ~at_breakpoint & b_d.
- States: SCAN, SELECT, BRK_VIEW. Reset state is SCAN.
- SCAN: on tick, read_addr <= read_addr+1. After {SCAN_LAST,1} it wraps to {0,0}.
- SELECT:
  - Every cycle, if addr_in != read_addr[6:1]: read_addr <= {addr_in,0}.
  - Otherwise, on tick, read_addr[0] toggles.
- SCAN/SELECT + mode_edge:
  - mode toggles and the state switches to the other mode.
  - Entering SELECT: read_addr <= {addr_in,0}. Entering SCAN: read_addr <= 0.
- Any state + brk_rise:
  - save_addr <= read_addr; state BRK_VIEW; read_addr <= 0; in_brk <= 1.
  - In BRK_VIEW, on tick, read_addr increments and wraps {WATCH_LAST,1} -> 0.
- BRK_VIEW + mode_edge: mode toggles only; the address is unaffected.
- BRK_VIEW + brk_fall:
  - in_brk <= 0; state <= mode ? SELECT : SCAN.
  - read_addr <= mode ? {addr_in,0} : save_addr.
- Priority when events coincide in one cycle: brk_rise/brk_fall > mode_edge > select address change > tick.
  - A mode_edge coinciding with brk_rise still toggles mode.
  - A mode_edge coinciding with brk_fall toggles mode before the exit target is chosen.
- step pulses on any read_addr load: tick advance, jump, or restore.

## Timing

- Reset values (asserted asynchronously, immediately):
  - read_addr = 0, led = 0, high_low = 1, mode = 0, in_brk = 0, step = 0.
  - prescaler = 0, m_d = 0, b_d = 0, save_addr = 0, state SCAN.
- Input to output latency is 1 cycle.
  - A mode_btn or at_breakpoint rise sampled at edge k is visible on outputs after edge k.
  - addr_in sampled at edge k is visible on read_addr after edge k.
- After reset release or any prescaler clear, the first tick occurs TICK_DIV cycles later. Steady state is one advance per TICK_DIV cycles.
- A button held high yields exactly one mode_edge. A re-press needs mode_btn low for at least 1 cycle.
- at_breakpoint pulses of 1 cycle must give exactly one entry and one exit.
- rst during BRK_VIEW discards save_addr and returns to SCAN at address 0.

## Test plan

Bench parameters: TICK_DIV=4, SCAN_LAST=63, WATCH_LAST=3.

- **Scan and wrap:** release rst, hold all inputs low.
  - read_addr = 0,1,2,... changing every 4 cycles, step high once per change.
  - After 127 it becomes 0; high_low alternates 1,0.
- **Select:** pulse mode_btn with addr_in=5.
  - Next cycle: mode=1, read_addr=10, led=5.
  - 4 cycles later read_addr=11, 4 cycles after that 10.
  - Change addr_in to 9 while at 11: read_addr=18 next cycle, and the following step comes 4 cycles later.
- **Watch window:** in SCAN at read_addr=37, raise at_breakpoint.
  - Next cycle: in_brk=1, read_addr=0; it then cycles 0..7 and wraps.
  - Drop at_breakpoint: read_addr=37, in_brk=0, mode=0.
- **Coincident events:** in SCAN with addr_in=12, rise mode_btn and at_breakpoint in the same cycle.
  - in_brk=1, mode=1, read_addr=0.
  - On exit: state SELECT, read_addr=24.
- **Mode edge inside window:** in BRK_VIEW, pulse mode_btn twice.
  - mode 0->1->0; read_addr sequence unaffected.
  - On exit, the saved scan address is restored.
- **Reset mid-operation:** assert rst while in BRK_VIEW at read_addr=5 and mode=1.
  - All outputs take their reset values immediately.
  - After release, scan restarts at 0 with the first step 4 cycles later.
